// File: rtl/memory_writer_input.sv
`timescale 1ns/1ps
// memory_writer_input: takes an AXI-Stream video frame and writes it to memory as one INCR burst.
// Define MEMORY_WRITER_DOUBLE_BUFFER_EN to alternate frames between two buffers.
module memory_writer_input #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_height,
    input  logic [15:0]           frame_width,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  start_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [31:0]           write_len,
    output logic [2:0]            write_size,
    output logic [1:0]            write_burst,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  frame_ready,
    output logic [ADDR_WIDTH-1:0] frame_addr,
    output logic                  line_err
);

    typedef enum logic [1:0] {IDLE, ADDR, WRITE, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic [15:0]           width_q;
    logic [15:0]           height_q;
    logic [15:0]           pixel_cnt;
    logic [15:0]           line_cnt;
    logic                  pix_last;
    logic                  line_last;
    logic                  sof;
    logic                  xfer;
    logic                  resp_done;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] sof_addr;

    assign sof       = (state == IDLE) && s_axis_tvalid && s_axis_tuser;
    assign xfer      = (state == WRITE) && s_axis_tvalid && wready;
    assign resp_done = (state == RESP) && bvalid;
    assign pix_last  = (pixel_cnt == width_q - 16'd1);
    assign line_last = (line_cnt == height_q - 16'd1);
    assign beat_err  = (s_axis_tlast != pix_last) ||
                       (s_axis_tuser && ((pixel_cnt != 16'd0) || (line_cnt != 16'd0)));

    assign write_len   = {16'b0, width_q} * {16'b0, height_q};
    assign write_size  = 3'b010;
    assign write_burst = 2'b01;

`ifdef MEMORY_WRITER_DOUBLE_BUFFER_EN
    localparam int BYTES = DATA_WIDTH / 8;

    logic        buf_sel;
    logic [31:0] frame_bytes;

    // Second buffer sits directly after the first, sized from the dimensions being sampled now.
    assign frame_bytes = {16'b0, frame_width} * {16'b0, frame_height} * 32'(BYTES);
    assign sof_addr    = buf_sel ? base_addr + ADDR_WIDTH'(frame_bytes) : base_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel <= 1'b0;
        end else if (resp_done) begin
            buf_sel <= ~buf_sel;
        end
    end
`else
    assign sof_addr = base_addr;
`endif

    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sof) state_next = ADDR;
            ADDR:    if (awready) state_next = WRITE;
            WRITE:   if (xfer && pix_last && line_last) state_next = RESP;
            RESP:    if (bvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every always_comb output is given a default first so no latch can be inferred.
    always_comb begin
        start_write   = 1'b0;
        s_axis_tready = 1'b0;
        wvalid        = 1'b0;
        wdata         = '0;
        wlast         = 1'b0;
        case (state)
            IDLE:  s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
            ADDR:  start_write   = 1'b1;
            WRITE: begin
                s_axis_tready = wready;
                wvalid        = s_axis_tvalid;
                wdata         = s_axis_tdata;
                wlast         = pix_last && line_last;
            end
            default: ;
        endcase
    end

    // Geometry and address are frozen at start of frame; the stream cannot change them mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q     <= '0;
            height_q    <= '0;
            write_addr  <= '0;
            pixel_cnt   <= '0;
            line_cnt    <= '0;
            line_err    <= 1'b0;
            frame_ready <= 1'b0;
            frame_addr  <= '0;
        end else begin
            frame_ready <= resp_done;
            if (resp_done) begin
                frame_addr <= write_addr;
            end
            if (sof) begin
                width_q    <= frame_width;
                height_q   <= frame_height;
                write_addr <= sof_addr;
                pixel_cnt  <= '0;
                line_cnt   <= '0;
                line_err   <= 1'b0;
            end else if (xfer) begin
                if (beat_err) begin
                    line_err <= 1'b1;
                end
                if (pix_last) begin
                    pixel_cnt <= '0;
                    line_cnt  <= line_last ? 16'd0 : line_cnt + 16'd1;
                end else begin
                    pixel_cnt <= pixel_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/memory_writer_input.md
MEMORY_WRITER_INPUT -- requirements
Module: memory_writer_input

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel/word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_height  in  16  lines per frame, 1..720.
- frame_width  in  16  pixels per line, 1..1280.
- base_addr  in  ADDR_WIDTH  frame buffer byte address.
- s_axis_tdata  in  DATA_WIDTH  pixel.
- s_axis_tvalid  in  1  pixel valid.
- s_axis_tready  out  1  pixel accepted.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame.
- start_write  out  1  write burst request.
- write_addr  out  ADDR_WIDTH  burst start address.
- write_len  out  32  burst length in beats.
- write_size  out  3  beat size.
- write_burst  out  2  burst type.
- awready  in  1  address accepted.
- wdata  out  DATA_WIDTH  write data.
- wvalid  out  1  write data valid.
- wready  in  1  write data accepted.
- wlast  out  1  final beat.
- bvalid  in  1  write response.
- frame_ready  out  1  one-cycle pulse, frame complete in memory.
- frame_addr  out  ADDR_WIDTH  address of the completed frame.
- line_err  out  1  sticky framing error.

Function
REQ-004 SHALL implement states IDLE, ADDR, WRITE, RESP.
REQ-005 IDLE: s_axis_tready = NOT(s_axis_tvalid AND s_axis_tuser); beats without tuser SHALL be dropped.
REQ-006 IDLE -> ADDR when s_axis_tvalid AND s_axis_tuser; SOF beat SHALL NOT be consumed in IDLE; write_addr latched from buffer address (REQ-016); line_err cleared.
REQ-007 ADDR: start_write=1, s_axis_tready=0; -> WRITE on awready.
REQ-008 write_len SHALL be frame_height*frame_width (32-bit product); write_size=3'b010; write_burst=2'b01 (INCR); both constant in all states.
REQ-009 WRITE: wdata=s_axis_tdata, wvalid=s_axis_tvalid, s_axis_tready=wready; transfer = tvalid AND wready, zero added latency.
REQ-010 Per transfer: pixel_cnt increments; at frame_width-1 wraps to 0 and line_cnt increments.
REQ-011 wlast SHALL be 1 when pixel_cnt==frame_width-1 AND line_cnt==frame_height-1; transfer with wlast -> RESP.
REQ-012 line_err SHALL set when a transfer has s_axis_tlast != (pixel_cnt==frame_width-1), or s_axis_tuser=1 with pixel_cnt or line_cnt nonzero; beat still written, counters unaffected.
REQ-013 RESP: s_axis_tready=0, wvalid=0; on bvalid -> IDLE, frame_ready=1 for exactly that cycle's successor (registered pulse), frame_addr = write_addr of that frame.
REQ-014 frame_height, frame_width, base_addr SHALL be sampled only on IDLE->ADDR; changes mid-frame ignored.
REQ-015 bvalid outside RESP SHALL be ignored; awready outside ADDR ignored.

Reset
REQ-016 On rst_n low: state IDLE, counters 0, all outputs 0 except write_size/write_burst/write_len (constant), line_err 0, buffer select 0; partial frame abandoned, no frame_ready.

Configuration
REQ-017 Macro MEMORY_WRITER_DOUBLE_BUFFER_EN defined: buffer select toggles on each frame_ready; frame address = base_addr when select 0, base_addr + frame_width*frame_height*(DATA_WIDTH/8) when 1.
REQ-018 Macro undefined: every frame written at base_addr; no buffer select state.

Verification
REQ-019 4x2 frame, SOF at beat 0, tlast at beats 3,7, wready=1, awready after 2 cycles -> start_write held 2 cycles, write_len=8, 8 beats, wlast on beat 7, frame_ready one cycle after bvalid, line_err=0.
REQ-020 3 beats without tuser, then 4x2 frame -> first 3 accepted and dropped, no start_write until SOF.
REQ-021 wready toggling 1,0 each cycle -> s_axis_tready mirrors wready; all 8 pixels written in order, none duplicated.
REQ-022 4x2 frame with tlast at beat 2 instead of 3 -> line_err=1 until next SOF, wlast still on beat 7.
REQ-023 With MEMORY_WRITER_DOUBLE_BUFFER_EN, base_addr=0x1000, 4x2 frames x3 -> write_addr 0x1000, 0x1020, 0x1000.
REQ-024 rst_n low after beat 4 of 4x2 frame -> IDLE, no frame_ready; next SOF frame completes normally at base_addr.
